modulo_condicionador_entradas: RTL and testbench

Input conditioning stage between the board's raw push-buttons and switches and the game datapath (position/attack register matrices, 7-segment and LED-matrix scan). It synchronises and debounces the two active-low buttons into single-cycle pulses, and snapshots the coordinate switches on each accepted shot. It rejects off-grid coordinates and keeps a saturating shot counter. Its outputs drive the matrix clock/clear enables and the selector logic directly.

---
 rtl/modulo_condicionador_entradas.sv | 206 ++++++++++++++++++++
 tb/tb_modulo_condicionador_entradas.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/modulo_condicionador_entradas.sv
// Input conditioning stage: synchronises the raw buttons and switches,
// debounces each button into a single press event, and turns those events
// into fire/clear/error pulses with a latched coordinate and a shot counter.

// Debounce FSM for one synchronised, active-low button level.
// press_o is combinational and high only on the DEB_PRESS -> HELD transition.
module DebounceFsm #(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic clr,
    input  logic level_i,
    output logic press_o
);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers; reset abandons any debounce in progress.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: a level must hold DEB_CYCLES cycles to be accepted,
    // and only the press side produces an event.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!level_i) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (level_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    press_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (level_i) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = '0;
                end
            end
            DEB_RELEASE: begin
                if (!level_i) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

module modulo_condicionador_entradas #(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_fire_n,
    input  logic       btn_clr_n,
    input  logic [5:0] sw_coord,
    input  logic [1:0] sw_mode,
    output logic       fire_pulse,
    output logic       clr_pulse,
    output logic       err_pulse,
    output logic [5:0] coord_lat,
    output logic [1:0] mode_sync,
    output logic [3:0] shots
);

    // Bit 1 is the fire button, bit 0 the clear button.
    logic [1:0] btnS1_q, btnS2_q;
    logic [5:0] coordS1_q, coordS2_q;
    logic [1:0] modeS1_q, modeS2_q;

    logic       firePress, clrPress, coordValid;

    logic       firePulse_q, firePulse_d;
    logic       clrPulse_q, clrPulse_d;
    logic       errPulse_q, errPulse_d;
    logic [5:0] coordLat_q, coordLat_d;
    logic [3:0] shots_q, shots_d;

    // Two-flop synchronisers; buttons reset to released, switches to zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            btnS1_q   <= 2'b11;
            btnS2_q   <= 2'b11;
            coordS1_q <= '0;
            coordS2_q <= '0;
            modeS1_q  <= '0;
            modeS2_q  <= '0;
        end else begin
            btnS1_q   <= {btn_fire_n, btn_clr_n};
            btnS2_q   <= btnS1_q;
            coordS1_q <= sw_coord;
            coordS2_q <= coordS1_q;
            modeS1_q  <= sw_mode;
            modeS2_q  <= modeS1_q;
        end
    end

    DebounceFsm #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) fireDeb (
        .clk     (clk),
        .clr     (clr),
        .level_i (btnS2_q[1]),
        .press_o (firePress)
    );

    DebounceFsm #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) clrDeb (
        .clk     (clk),
        .clr     (clr),
        .level_i (btnS2_q[0]),
        .press_o (clrPress)
    );

    assign coordValid = (coordS2_q[5:3] <= 3'd6) && (coordS2_q[2:0] <= 3'd4);

    // Event resolution: clear beats fire; off-grid shots only raise an error.
    always_comb begin
        firePulse_d = 1'b0;
        clrPulse_d  = 1'b0;
        errPulse_d  = 1'b0;
        coordLat_d  = coordLat_q;
        shots_d     = shots_q;
        if (clrPress) begin
            clrPulse_d = 1'b1;
            coordLat_d = '0;
            shots_d    = '0;
        end else if (firePress) begin
            if (coordValid) begin
                firePulse_d = 1'b1;
                coordLat_d  = coordS2_q;
                shots_d     = (shots_q == 4'd15) ? shots_q : shots_q + 4'd1;
            end else begin
                errPulse_d = 1'b1;
            end
        end
    end

    // Output registers, all updated on the same edge as the event.
    always_ff @(posedge clk) begin
        if (clr) begin
            firePulse_q <= 1'b0;
            clrPulse_q  <= 1'b0;
            errPulse_q  <= 1'b0;
            coordLat_q  <= '0;
            shots_q     <= '0;
        end else begin
            firePulse_q <= firePulse_d;
            clrPulse_q  <= clrPulse_d;
            errPulse_q  <= errPulse_d;
            coordLat_q  <= coordLat_d;
            shots_q     <= shots_d;
        end
    end

    assign fire_pulse = firePulse_q;
    assign clr_pulse  = clrPulse_q;
    assign err_pulse  = errPulse_q;
    assign coord_lat  = coordLat_q;
    assign mode_sync  = modeS2_q;
    assign shots      = shots_q;

endmodule

// File: tb/tb_modulo_condicionador_entradas.sv
// Scoreboard bench for modulo_condicionador_entradas with a short debounce.
module tb_modulo_condicionador_entradas;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       btn_fire_n, btn_clr_n;
    logic [5:0] sw_coord;
    logic [1:0] sw_mode;
    logic       fire_pulse, clr_pulse, err_pulse;
    logic [5:0] coord_lat;
    logic [1:0] mode_sync;
    logic [3:0] shots;

    typedef struct {
        int         cyc;
        logic       f;
        logic       c;
        logic       e;
        logic [5:0] coord;
        logic [3:0] shots;
    } exp_t;

    exp_t       sbQ[$];
    exp_t       popped;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [5:0] expCoord = '0;
    logic [3:0] expShots = '0;

    modulo_condicionador_entradas #(
        .DEB_CYCLES (DEB),
        .CNT_W      (3)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .btn_fire_n (btn_fire_n),
        .btn_clr_n  (btn_clr_n),
        .sw_coord   (sw_coord),
        .sw_mode    (sw_mode),
        .fire_pulse (fire_pulse),
        .clr_pulse  (clr_pulse),
        .err_pulse  (err_pulse),
        .coord_lat  (coord_lat),
        .mode_sync  (mode_sync),
        .shots      (shots)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic pushExp(input int c, input logic f, input logic cl, input logic e);
        exp_t x;
        x.cyc   = c;
        x.f     = f;
        x.c     = cl;
        x.e     = e;
        x.coord = expCoord;
        x.shots = expShots;
        sbQ.push_back(x);
    endtask

    // Monitor: every presented pulse must match the next expected event.
    always @(negedge clk) begin
        if (fire_pulse === 1'b1 || clr_pulse === 1'b1 || err_pulse === 1'b1) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got fire=%b clr=%b err=%b expected none at cycle %0d",
                         fire_pulse, clr_pulse, err_pulse, cyc);
            end else begin
                popped = sbQ.pop_front();
                checkOutput("pulse_cycle", cyc, popped.cyc);
                checkOutput("fire_pulse", int'(fire_pulse), int'(popped.f));
                checkOutput("clr_pulse", int'(clr_pulse), int'(popped.c));
                checkOutput("err_pulse", int'(err_pulse), int'(popped.e));
                checkOutput("coord_lat", int'(coord_lat), int'(popped.coord));
                checkOutput("shots", int'(shots), int'(popped.shots));
            end
        end
    end

    // Press one or both buttons with the coordinate settled beforehand;
    // the pulse is expected 6 edges after the first sample of the low level.
    task automatic applyStimulus(input logic useFire, input logic useClr,
                                 input logic [5:0] coord, input int hold, input int rel);
        sw_coord = coord;
        repeat (3) @(negedge clk);
        if (useClr) begin
            expCoord = '0;
            expShots = '0;
            pushExp(cyc + 3 + DEB, 1'b0, 1'b1, 1'b0);
        end else if (useFire) begin
            if (coord[5:3] <= 3'd6 && coord[2:0] <= 3'd4) begin
                expCoord = coord;
                if (expShots != 4'd15) expShots = expShots + 4'd1;
                pushExp(cyc + 3 + DEB, 1'b1, 1'b0, 1'b0);
            end else begin
                pushExp(cyc + 3 + DEB, 1'b0, 1'b0, 1'b1);
            end
        end
        if (useFire) btn_fire_n = 1'b0;
        if (useClr) btn_clr_n = 1'b0;
        repeat (hold) @(negedge clk);
        btn_fire_n = 1'b1;
        btn_clr_n  = 1'b1;
        repeat (rel) @(negedge clk);
    endtask

    initial begin
        clr        = 1'b1;
        btn_fire_n = 1'b1;
        btn_clr_n  = 1'b1;
        sw_coord   = '0;
        sw_mode    = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_fire", int'(fire_pulse), 0);
        checkOutput("rst_clr", int'(clr_pulse), 0);
        checkOutput("rst_err", int'(err_pulse), 0);
        checkOutput("rst_coord", int'(coord_lat), 0);
        checkOutput("rst_shots", int'(shots), 0);
        checkOutput("rst_mode", int'(mode_sync), 0);

        clr = 1'b0;
        @(negedge clk);

        // mode_sync follows sw_mode two edges later
        sw_mode = 2'b10;
        @(negedge clk);
        checkOutput("mode_lag1", int'(mode_sync), 0);
        @(negedge clk);
        checkOutput("mode_lag2", int'(mode_sync), 2);
        sw_mode = 2'b01;
        @(negedge clk);
        checkOutput("mode_lag1b", int'(mode_sync), 2);
        @(negedge clk);
        checkOutput("mode_lag2b", int'(mode_sync), 1);

        // Clean valid shot
        applyStimulus(1'b1, 1'b0, 6'b010_011, 20, 12);

        // Bouncy press: short lows never survive the debounce
        sw_coord = 6'b001_100;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            btn_fire_n = (i % 2 == 1);
            repeat (2) @(negedge clk);
        end
        expCoord = 6'b001_100;
        expShots = expShots + 4'd1;
        pushExp(cyc + 3 + DEB, 1'b1, 1'b0, 1'b0);
        btn_fire_n = 1'b0;
        repeat (10) @(negedge clk);
        btn_fire_n = 1'b1;
        repeat (12) @(negedge clk);

        // Off-grid shot
        applyStimulus(1'b1, 1'b0, 6'b111_000, 10, 12);
        checkOutput("err_keeps_coord", int'(coord_lat), 6'b001_100);
        checkOutput("err_keeps_shots", int'(shots), 2);

        // Saturation of the shot counter
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 1'b0, {3'(i % 7), 3'(i % 5)}, 8, 10);
        end
        checkOutput("shots_saturated", int'(shots), 15);

        // Clear button
        applyStimulus(1'b0, 1'b1, 6'b011_001, 8, 10);
        checkOutput("clr_shots", int'(shots), 0);
        checkOutput("clr_coord", int'(coord_lat), 0);

        // Simultaneous presses: clear wins, then a fresh fire counts once
        applyStimulus(1'b1, 1'b1, 6'b100_010, 8, 10);
        applyStimulus(1'b1, 1'b0, 6'b100_010, 8, 10);
        checkOutput("after_simul_shots", int'(shots), 1);

        // Reset two edges after the press sample, button still held
        sw_coord = 6'b000_001;
        repeat (3) @(negedge clk);
        btn_fire_n = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        expCoord = '0;
        expShots = '0;
        checkOutput("midrst_shots", int'(shots), 0);
        checkOutput("midrst_coord", int'(coord_lat), 0);
        expCoord = 6'b000_001;
        expShots = 4'd1;
        pushExp(cyc + 3 + DEB, 1'b1, 1'b0, 1'b0);
        clr = 1'b0;
        repeat (12) @(negedge clk);
        btn_fire_n = 1'b1;
        repeat (10) @(negedge clk);

        // Bounded drain of any outstanding expectations
        for (int w = 0; w < 50 && sbQ.size() != 0; w++) @(negedge clk);
        checkOutput("sb_drained", sbQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
